ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 12000, clock-low hold time for the request-to-send phase (120 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000, maximum clk cycles allowed between successive device clock edges (20 ms).
REQ-003 Parameter FILTER_LEN, default 8, number of consecutive equal samples needed to accept a new ps2c level.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 wr_ps2  in  1  one-cycle start request; din is captured in the same cycle.
REQ-007 din  in  8  command byte to send to the keyboard.
REQ-008 ps2c_in  in  1  sampled PS/2 clock line.
REQ-009 ps2d_in  in  1  sampled PS/2 data line.
REQ-010 ps2c_oe  out  1  1 = pull PS/2 clock low; 0 = release the line (top-level open-drain).
REQ-011 ps2d_oe  out  1  1 = pull PS/2 data low; 0 = release the line.
REQ-012 tx_idle  out  1  1 when in IDLE; the keyboard receiver is enabled only while this is 1.
REQ-013 tx_done_tick  out  1  one-cycle pulse at frame end, valid for success and for failure.
REQ-014 ack_err  out  1  qualified by tx_done_tick; 1 = NACK or timeout.

Function
REQ-015 FSM states: IDLE, RTS, START, DATA, STOP, ACK, WAIT_REL.
REQ-016 IDLE: both oe = 0; on wr_ps2=1, load shift register = {odd parity of din, din} (9 bits); go to RTS.
REQ-017 wr_ps2 outside IDLE is ignored; the frame in progress is unaffected.
REQ-018 RTS: ps2c_oe = 1 and ps2d_oe = 1 for exactly INHIBIT_CYCLES cycles, then go to START.
REQ-019 START: ps2c_oe = 0 and ps2d_oe = 1 (start bit); on the first filtered ps2c falling edge go to DATA.
REQ-020 DATA: ps2d_oe = ~shreg[0]; each falling edge shifts shreg right; after the 9th bit (data LSB-first, then parity) has been presented, the next falling edge goes to STOP.
REQ-021 Edge count: falling edges 1-8 present data bits 0-7, edge 9 presents parity, and edge 10 releases data (stop bit = 1).
REQ-022 STOP: ps2d_oe = 0; on falling edge 11, sample ps2d_in and go to ACK.
REQ-023 ACK: the sample from edge 11 sets ack_err = ps2d_in (0 means the device acknowledged); go to WAIT_REL.
REQ-024 WAIT_REL: wait until filtered ps2c = 1 and ps2d_in = 1, then pulse tx_done_tick and return to IDLE.
REQ-025 Timeout: in START through WAIT_REL, the edge watchdog counter resets on every filtered falling edge.
REQ-026 When the watchdog reaches TIMEOUT_CYCLES, release both lines, set ack_err = 1, pulse tx_done_tick and go to IDLE in the same cycle.
REQ-027 Edges are detected only from the filtered ps2c; a filtered falling edge is registered one cycle after the filter output changes.
REQ-028 Parity is odd: the parity bit is set so that the 8 data bits plus parity contain an odd number of ones.
REQ-029 ack_err holds its value until the next tx_done_tick.

Reset
REQ-030 While reset = 0: state = IDLE, ps2c_oe = 0, ps2d_oe = 0, tx_done_tick = 0, ack_err = 0, tx_idle = 1, and all counters and shreg are 0.
REQ-031 A reset asserted mid-frame releases both lines asynchronously, with no done pulse.

Structure
REQ-032 The shared package ps2_pkg holds the state enum, default INHIBIT/TIMEOUT/FILTER constants, and the parity function.
REQ-033 The sub-module ps2_clk_filter (FILTER_LEN-sample debounce plus falling-edge tick) is instantiated once and shared with the keyboard receiver.

Verification
REQ-034 din=0xED with a device model that ACKs -> after 12000 cycles of clock low, data bits 1,0,1,1,0,1,1,1 then parity 1 and stop 1; ack_err=0 with one tx_done_tick.
REQ-035 din=0x00 with a device model that NACKs (data high at edge 11) -> parity 1, tx_done_tick pulses with ack_err=1.
REQ-036 No device clock after RTS -> tx_done_tick with ack_err=1 exactly TIMEOUT_CYCLES cycles after entering START, and both oe = 0.
REQ-037 wr_ps2 pulsed during DATA with din=0xFF -> ignored; the frame in progress completes unchanged and only one done pulse occurs.
REQ-038 reset asserted at edge 5 -> ps2c_oe=ps2d_oe=0 immediately and tx_idle=1; a new wr_ps2 after release sends a full frame.
REQ-039 Glitches shorter than FILTER_LEN cycles on ps2c during DATA -> no extra bit shifted and the frame is still correct.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, default timing constants and parity helper.
package ps2_pkg;

    localparam int unsigned DefInhibitCycles = 12000;
    localparam int unsigned DefTimeoutCycles = 2000000;
    localparam int unsigned DefFilterLen     = 8;

    typedef enum logic [2:0] {
        StIdle,
        StRts,
        StStart,
        StData,
        StStop,
        StAck,
        StWaitRel
    } ps2_tx_state_e;

    // Odd parity: data plus parity bit always carry an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock debounce: a new level is accepted after FILTER_LEN equal samples; a registered
// falling-edge tick follows one cycle after the filtered level drops.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = DefFilterLen
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ps2c_i,
    output logic ps2c_filt_o,
    output logic fall_tick_o
);

    localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            filt_q, filt_d;
    logic            filt_prev_q;
    logic            fall_q;

    // Any sample equal to the current level restarts the run of differing samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (ps2c_i != filt_q) begin
            if (cnt_q == CntW'(FILTER_LEN - 1)) begin
                filt_d = ps2c_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fall_q      <= filt_prev_q & ~filt_q;
        end
    end

    assign ps2c_filt_o = filt_q;
    assign fall_tick_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 11-clock frame, device ACK check
// and an edge watchdog that aborts a stalled frame.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DefInhibitCycles,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
    parameter int unsigned FILTER_LEN     = DefFilterLen
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err
);

    localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    ps2_tx_state_e   state_q;
    logic [8:0]      shreg_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      bit_cnt_q;
    logic            ack_bit_q;
    logic            ps2c_oe_q;
    logic            ps2d_oe_q;
    logic            idle_q;
    logic            done_q;
    logic            ack_err_q;

    logic            ps2c_filt;
    logic            fall_tick;
    logic            wdog_active;
    logic            wdog_expired;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk_i      (clk),
        .rst_ni     (reset),
        .ps2c_i     (ps2c_in),
        .ps2c_filt_o(ps2c_filt),
        .fall_tick_o(fall_tick)
    );

    // RTS and the watchdog never overlap, so they share one counter.
    assign wdog_active  = !(state_q inside {StIdle, StRts});
    assign wdog_expired = wdog_active && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            ack_bit_q <= 1'b0;
            ps2c_oe_q <= 1'b0;
            ps2d_oe_q <= 1'b0;
            idle_q    <= 1'b1;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wdog_expired) begin
                state_q   <= StIdle;
                cnt_q     <= '0;
                ps2c_oe_q <= 1'b0;
                ps2d_oe_q <= 1'b0;
                idle_q    <= 1'b1;
                done_q    <= 1'b1;
                ack_err_q <= 1'b1;
            end else begin
                if (wdog_active) begin
                    cnt_q <= fall_tick ? '0 : cnt_q + 1'b1;
                end
                unique case (state_q)
                    StIdle: begin
                        if (wr_ps2) begin
                            shreg_q   <= {odd_parity(din), din};
                            cnt_q     <= '0;
                            bit_cnt_q <= '0;
                            ps2c_oe_q <= 1'b1;
                            ps2d_oe_q <= 1'b1;
                            idle_q    <= 1'b0;
                            state_q   <= StRts;
                        end
                    end
                    StRts: begin
                        if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
                            cnt_q     <= '0;
                            ps2c_oe_q <= 1'b0;
                            state_q   <= StStart;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StStart: begin
                        if (fall_tick) begin
                            ps2d_oe_q <= ~shreg_q[0];
                            bit_cnt_q <= '0;
                            state_q   <= StData;
                        end
                    end
                    StData: begin
                        // Edge 1 already presented data bit 0; edges 2..9 shift in the rest.
                        if (fall_tick) begin
                            if (bit_cnt_q == 4'd8) begin
                                ps2d_oe_q <= 1'b0;
                                state_q   <= StStop;
                            end else begin
                                shreg_q   <= {1'b0, shreg_q[8:1]};
                                ps2d_oe_q <= ~shreg_q[1];
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    StStop: begin
                        if (fall_tick) begin
                            ack_bit_q <= ps2d_in;
                            state_q   <= StAck;
                        end
                    end
                    StAck: begin
                        state_q <= StWaitRel;
                    end
                    StWaitRel: begin
                        if (ps2c_filt && ps2d_in) begin
                            cnt_q     <= '0;
                            idle_q    <= 1'b1;
                            done_q    <= 1'b1;
                            ack_err_q <= ack_bit_q;
                            state_q   <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign ps2c_oe      = ps2c_oe_q;
    assign ps2d_oe      = ps2d_oe_q;
    assign tx_idle      = idle_q;
    assign tx_done_tick = done_q;
    assign ack_err      = ack_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host; a scoreboard
// monitor checks every done pulse against the expected outcome queued at issue time.
module tb_ps2_host_tx;

    localparam int unsigned Inhibit = 40;
    localparam int unsigned Timeout = 600;
    localparam int unsigned FLen    = 4;
    localparam int          Half    = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2c_line, ps2d_line;
    logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, ack_err;

    typedef struct {
        string      name;
        logic       ack;
        logic       chk_frame;
        logic [9:0] frame;
        int         latency;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] cap_frame = '0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         n_done = 0;

    // Open-drain wired-AND of host and device drivers.
    assign ps2c_line = dev_clk & ~ps2c_oe;
    assign ps2d_line = dev_data & ~ps2d_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(Inhibit),
        .TIMEOUT_CYCLES(Timeout),
        .FILTER_LEN    (FLen)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps2c_in     (ps2c_line),
        .ps2d_in     (ps2d_line),
        .ps2c_oe     (ps2c_oe),
        .ps2d_oe     (ps2d_oe),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .ack_err     (ack_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Host releasing the clock marks entry to the start-bit phase.
    initial begin
        logic prev_coe;
        prev_coe = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_coe && !ps2c_oe) start_cyc = cyc;
            prev_coe = ps2c_oe;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_done_tick) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got a done pulse at cycle %0d, expected none",
                             cyc);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_ack_err"}, int'(ack_err), int'(e.ack));
                    if (e.chk_frame) check({e.name, "_frame"}, int'(cap_frame), int'(e.frame));
                    if (e.latency > 0) check({e.name, "_latency"}, cyc - start_cyc, e.latency);
                    check({e.name, "_lines_released"}, int'({ps2c_oe, ps2d_oe}), 0);
                    check({e.name, "_idle"}, int'(tx_idle), 1);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        din    = d;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
    endtask

    task automatic expect_done(input string name, input logic ack, input logic chk,
                               input logic [9:0] frame, input int latency);
        exp_t e;
        e.name      = name;
        e.ack       = ack;
        e.chk_frame = chk;
        e.frame     = frame;
        e.latency   = latency;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int bound);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < bound) begin
            g++;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_no_done: got no done pulse within %0d cycles, expected one",
                     name, bound);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Device side of one frame; glitch_mask bit e adds sub-filter pulses around edge e.
    task automatic dev_frame(input logic ack, input int glitch_mask, input int wr_edge,
                             input int abort_edge);
        int  g;
        int  n;
        logic gl;
        g = 0;
        n = 0;
        cap_frame = '0;
        while (!ps2c_oe && g < 100) begin
            g++;
            @(negedge clk);
        end
        while (ps2c_oe && n < 4 * Inhibit) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, Inhibit);
        check("start_bit_oe", int'(ps2d_oe), 1);
        repeat (10) @(negedge clk);
        for (int e = 1; e <= 11; e++) begin
            gl = ((glitch_mask >> e) & 1) != 0;
            if (e == 11 && ack) begin
                dev_data = 1'b0;
                repeat (2) @(negedge clk);
            end
            if (e == abort_edge) begin
                dev_clk = 1'b0;
                repeat (8) @(negedge clk);
                check("abort_pre_oe", int'(ps2d_oe), 1);
                reset = 1'b0;
                #1;
                check("abort_lines", int'({ps2c_oe, ps2d_oe}), 0);
                check("abort_idle", int'(tx_idle), 1);
                check("abort_ack_err", int'(ack_err), 0);
                @(negedge clk);
                reset   = 1'b1;
                dev_clk = 1'b1;
                return;
            end
            for (int k = 0; k < Half; k++) begin
                dev_clk = (gl && k >= 6 && k < 6 + int'(FLen) - 1);
                if (e == wr_edge) din = 8'hFF;
                wr_ps2 = (e == wr_edge && k == 7);
                @(negedge clk);
            end
            wr_ps2  = 1'b0;
            dev_clk = 1'b1;
            if (e <= 10) cap_frame[e-1] = ps2d_line;
            for (int k = 0; k < Half; k++) begin
                dev_clk = !(gl && k >= 3 && k < 3 + int'(FLen) - 1);
                if (e == 11 && k == 2) dev_data = 1'b1;
                @(negedge clk);
            end
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ps2c_oe", int'(ps2c_oe), 0);
        check("rst_ps2d_oe", int'(ps2d_oe), 0);
        check("rst_tx_idle", int'(tx_idle), 1);
        check("rst_done", int'(tx_done_tick), 0);
        check("rst_ack_err", int'(ack_err), 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
        expect_done("ed_ack", 1'b0, 1'b1, 10'h3ED, 0);
        send(8'hED);
        dev_frame(1'b1, 0, 0, 0);
        wait_drain("ed_ack", 200);

        // 0x00 NACK: parity 1.
        expect_done("00_nack", 1'b1, 1'b1, 10'h300, 0);
        send(8'h00);
        dev_frame(1'b0, 0, 0, 0);
        wait_drain("00_nack", 200);
        repeat (5) @(negedge clk);
        check("ack_err_hold", int'(ack_err), 1);

        // No device clock: watchdog ends the frame Timeout cycles into the start phase.
        expect_done("timeout", 1'b1, 1'b0, 10'h000, int'(Timeout));
        send(8'h55);
        wait_drain("timeout", int'(Inhibit + Timeout) + 100);

        // 0x3C (four ones, parity 1) with a 0xFF write attempted mid-frame.
        expect_done("3c_wr_ignored", 1'b0, 1'b1, 10'h33C, 0);
        send(8'h3C);
        dev_frame(1'b1, 0, 4, 0);
        wait_drain("3c_wr_ignored", 200);

        // 0xA7 (five ones, parity 0) with clock glitches around edges 3 and 6.
        expect_done("a7_glitch", 1'b0, 1'b1, 10'h2A7, 0);
        send(8'hA7);
        dev_frame(1'b1, (1 << 3) | (1 << 6), 0, 0);
        wait_drain("a7_glitch", 200);

        // Reset at edge 5 aborts silently; the next frame (0x81, parity 1) goes out whole.
        send(8'h00);
        dev_frame(1'b1, 0, 0, 5);
        repeat (10) @(negedge clk);
        expect_done("81_after_reset", 1'b0, 1'b1, 10'h381, 0);
        send(8'h81);
        dev_frame(1'b1, 0, 0, 0);
        wait_drain("81_after_reset", 200);

        repeat (20) @(negedge clk);
        check("done_count", n_done, 6);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
